// File: rtl/fpu_sp_f2i.sv
// binary32 -> signed int32 converter, iterative one-bit-per-cycle shifter, truncating.
// Define FPU_F2I_RNE_EN to round to nearest-even instead of truncating.
module fpu_sp_f2i #(
    parameter logic [31:0] NAN_VALUE = 32'h7FFFFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic        dval,
    output logic        rdy,
    output logic [31:0] dout,
    output logic        dout_val,
    output logic        exc_invalid,
    output logic        exc_inexact
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_SHIFT,
        S_ROUND,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [31:0] op_q, op_d;
    logic [39:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        left_q, left_d;
    logic        guard_q, guard_d;
    logic        sticky_q, sticky_d;
    logic        nan_q, nan_d;
    logic        sat_q, sat_d;
    logic        min_q, min_d;
    logic [31:0] dout_q, dout_d;
    logic        dout_val_q, dout_val_d;
    logic        inv_q, inv_d;
    logic        inx_q, inx_d;

    logic [7:0]        exp_w;
    logic [22:0]       frac_w;
    logic signed [9:0] e_w;

    logic [4:0] n_w;
    logic       left_w, sub_w, nan_w, sat_w, min_w, g_w, s_w;
    logic [31:0] mag_w;

    assign exp_w  = op_q[30:23];
    assign frac_w = op_q[22:0];
    assign e_w    = $signed({2'b00, exp_w}) - 10'sd127;

    // Classify the captured operand and pick the shift direction/count.
    always_comb begin
        n_w    = '0;
        left_w = 1'b0;
        sub_w  = 1'b0;
        nan_w  = 1'b0;
        sat_w  = 1'b0;
        min_w  = 1'b0;
        g_w    = 1'b0;
        s_w    = 1'b0;
        if (exp_w == 8'hFF) begin
            nan_w = (frac_w != '0);
            sat_w = (frac_w == '0);
        end else if (exp_w == 8'h00 || e_w < 10'sd0) begin
            sub_w = 1'b1;
            g_w   = (exp_w != 8'h00) && (e_w == -10'sd1);
            s_w   = (exp_w == 8'h00) ? (frac_w != '0)
                                     : ((e_w < -10'sd1) || (frac_w != '0));
        end else if (e_w >= 10'sd31) begin
            // -2^31 is representable exactly, everything else up here saturates
            if (op_q[31] && e_w == 10'sd31 && frac_w == '0) begin
                min_w = 1'b1;
            end else begin
                sat_w = 1'b1;
            end
        end else if (e_w <= 10'sd22) begin
            n_w = 5'(10'sd23 - e_w);
        end else begin
            n_w    = 5'(e_w - 10'sd23);
            left_w = 1'b1;
        end
    end

    always_comb begin
        mag_w = acc_q[31:0];
`ifdef FPU_F2I_RNE_EN
        if (guard_q && (sticky_q || acc_q[0])) begin
            mag_w = acc_q[31:0] + 32'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (dval) state_d = S_UNPACK;
            S_UNPACK: state_d = (n_w == '0) ? S_ROUND : S_SHIFT;
            S_SHIFT:  if (cnt_q == 5'd1) state_d = S_ROUND;
            S_ROUND:  state_d = S_OUT;
            S_OUT:    state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdy = (state_q == S_IDLE);
    end

    always_comb begin
        op_d       = op_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        guard_d    = guard_q;
        sticky_d   = sticky_q;
        nan_d      = nan_q;
        sat_d      = sat_q;
        min_d      = min_q;
        dout_d     = dout_q;
        dout_val_d = 1'b0;
        inv_d      = inv_q;
        inx_d      = inx_q;
        case (state_q)
            S_IDLE: begin
                if (dval) op_d = din;
            end
            S_UNPACK: begin
                acc_d    = sub_w ? 40'd0 : {16'd0, 1'b1, frac_w};
                cnt_d    = n_w;
                left_d   = left_w;
                guard_d  = g_w;
                sticky_d = s_w;
                nan_d    = nan_w;
                sat_d    = sat_w;
                min_d    = min_w;
            end
            S_SHIFT: begin
                cnt_d = cnt_q - 5'd1;
                if (left_q) begin
                    acc_d = acc_q << 1;
                end else begin
                    acc_d    = acc_q >> 1;
                    guard_d  = acc_q[0];
                    sticky_d = sticky_q | guard_q;
                end
            end
            S_ROUND: begin
                dout_val_d = 1'b1;
                inv_d      = 1'b0;
                inx_d      = 1'b0;
                if (nan_q) begin
                    dout_d = NAN_VALUE;
                    inv_d  = 1'b1;
                end else if (sat_q) begin
                    dout_d = op_q[31] ? 32'h80000000 : 32'h7FFFFFFF;
                    inv_d  = 1'b1;
                end else if (min_q) begin
                    dout_d = 32'h80000000;
                end else begin
                    dout_d = op_q[31] ? (32'd0 - mag_w) : mag_w;
                    inx_d  = guard_q | sticky_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            left_q     <= 1'b0;
            guard_q    <= 1'b0;
            sticky_q   <= 1'b0;
            nan_q      <= 1'b0;
            sat_q      <= 1'b0;
            min_q      <= 1'b0;
            dout_q     <= '0;
            dout_val_q <= 1'b0;
            inv_q      <= 1'b0;
            inx_q      <= 1'b0;
        end else begin
            op_q       <= op_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            left_q     <= left_d;
            guard_q    <= guard_d;
            sticky_q   <= sticky_d;
            nan_q      <= nan_d;
            sat_q      <= sat_d;
            min_q      <= min_d;
            dout_q     <= dout_d;
            dout_val_q <= dout_val_d;
            inv_q      <= inv_d;
            inx_q      <= inx_d;
        end
    end

    assign dout        = dout_q;
    assign dout_val    = dout_val_q;
    assign exc_invalid = inv_q;
    assign exc_inexact = inx_q;

endmodule

// File: tb/tb_fpu_sp_f2i.sv
// Bench for fpu_sp_f2i: arithmetic reference model, scoreboard compare on every negedge,
// directed vectors with hand-computed literals, reset-abort and held-dval scenarios.
module tb_fpu_sp_f2i;

    localparam logic [31:0] NANV = 32'h7FFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic        dval;
    logic        rdy;
    logic [31:0] dout;
    logic        dout_val;
    logic        exc_invalid;
    logic        exc_inexact;

    fpu_sp_f2i #(.NAN_VALUE(NANV)) dut (
        .clk(clk), .rst(rst), .din(din), .dval(dval), .rdy(rdy),
        .dout(dout), .dout_val(dout_val),
        .exc_invalid(exc_invalid), .exc_inexact(exc_inexact)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] x;
        logic [31:0] r;
        logic        inv;
        logic        inx;
        int          lat;
        int          cap;
    } exp_t;
    exp_t q[$];

    // Reference: exact value m*2^(exp-150), then truncate (or RNE) and range-check.
    function automatic void model(input logic [31:0] x, output logic [31:0] r,
                                  output logic inv, output logic inx, output int lat);
        int ex, e, sh;
        bit s, ovf, rnd;
        longint unsigned full, mag, rem, half;
        s = x[31];
        ex = int'(x[30:23]);
        e = ex - 127;
        inv = 1'b0; inx = 1'b0; r = '0; ovf = 0; rnd = 0; mag = 0;
        if (ex == 255 || ex == 0 || e < 0 || e >= 31) lat = 2;
        else if (e <= 22) lat = 23 - e + 2;
        else lat = e - 23 + 2;
        if (ex == 255) begin
            inv = 1'b1;
            r = (x[22:0] != 0) ? NANV : (s ? 32'h80000000 : 32'h7FFFFFFF);
            return;
        end
        if (ex == 0) begin
            mag = 0;
            inx = (x[22:0] != 0);
        end else begin
            full = {40'd0, 1'b1, x[22:0]};
            if (ex - 150 >= 0) begin
                if (ex - 150 > 8) ovf = 1;
                else mag = full << (ex - 150);
            end else begin
                sh = 150 - ex;
                if (sh > 40) begin
                    mag = 0;
                    inx = 1'b1;
                end else begin
                    mag  = full >> sh;
                    rem  = full & ((64'd1 << sh) - 64'd1);
                    half = 64'd1 << (sh - 1);
                    inx  = (rem != 0);
                    rnd  = (rem > half) || (rem == half && mag[0]);
                end
            end
        end
`ifdef FPU_F2I_RNE_EN
        if (rnd) mag = mag + 1;
`endif
        if (ovf || (!s && mag > 64'h7FFFFFFF) || (s && mag > 64'h80000000)) begin
            inv = 1'b1;
            inx = 1'b0;
            r = s ? 32'h80000000 : 32'h7FFFFFFF;
        end else begin
            r = s ? (32'd0 - mag[31:0]) : mag[31:0];
        end
    endfunction

    // Scoreboard compare: every negedge, any dout_val must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && dout_val) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL spurious_dout_val dout=%08h cyc=%0d", dout, cyc);
            end else begin
                exp_t t;
                t = q.pop_front();
                $display("txn din=%08h dout=%08h inv=%0b inx=%0b lat=%0d", t.x, dout,
                         exc_invalid, exc_inexact, cyc - t.cap);
                checks++;
                if (dout !== t.r) begin
                    errors++;
                    $display("FAIL dout din=%08h got=%08h want=%08h", t.x, dout, t.r);
                end
                checks++;
                if (exc_invalid !== t.inv) begin
                    errors++;
                    $display("FAIL invalid din=%08h got=%0b want=%0b", t.x, exc_invalid, t.inv);
                end
                checks++;
                if (exc_inexact !== t.inx) begin
                    errors++;
                    $display("FAIL inexact din=%08h got=%0b want=%0b", t.x, exc_inexact, t.inx);
                end
                checks++;
                if (cyc - t.cap != t.lat) begin
                    errors++;
                    $display("FAIL latency din=%08h got=%0d want=%0d", t.x, cyc - t.cap, t.lat);
                end
            end
        end
    end

    task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", name, got, want);
        end
    endtask

    task automatic wait_rdy();
        int k;
        k = 0;
        @(negedge clk);
        while (!rdy && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL rdy_timeout got=0 want=1");
        end
    endtask

    task automatic capture(input logic [31:0] x, output int cap);
        din = x;
        dval = 1'b1;
        @(posedge clk);
        #1;
        dval = 1'b0;
        cap = cyc;
    endtask

    task automatic push(input logic [31:0] x, input int cap);
        exp_t t;
        t.x = x;
        t.cap = cap;
        model(x, t.r, t.inv, t.inx, t.lat);
        q.push_back(t);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL done_timeout pending=%0d want=0", q.size());
            q.delete();
        end
    endtask

    task automatic send(input logic [31:0] x);
        int cap;
        wait_rdy();
        capture(x, cap);
        push(x, cap);
        wait_done();
    endtask

    // Directed vectors with hand-computed results: {din, dout, invalid, inexact, latency}
    typedef struct {
        logic [31:0] x;
        logic [31:0] r;
        logic        inv;
        logic        inx;
        int          lat;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs[NV];

    initial begin
        vecs[0]  = '{32'h40490FDB, 32'h00000003, 1'b0, 1'b1, 24};
        vecs[1]  = '{32'hC2F6E979, 32'hFFFFFF85, 1'b0, 1'b1, 19};
        vecs[2]  = '{32'h4B800000, 32'h01000000, 1'b0, 1'b0, 3};
        vecs[3]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
        vecs[4]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 2};
        vecs[5]  = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 2};
        vecs[6]  = '{32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
        vecs[7]  = '{32'h80000000, 32'h00000000, 1'b0, 1'b0, 2};
        vecs[8]  = '{32'h00000001, 32'h00000000, 1'b0, 1'b1, 2};
`ifdef FPU_F2I_RNE_EN
        vecs[9]  = '{32'h3FC00000, 32'h00000002, 1'b0, 1'b1, 25};
        vecs[10] = '{32'h40200000, 32'h00000002, 1'b0, 1'b1, 24};
        vecs[11] = '{32'h3F400000, 32'h00000001, 1'b0, 1'b1, 2};
`else
        vecs[9]  = '{32'h3FC00000, 32'h00000001, 1'b0, 1'b1, 25};
        vecs[10] = '{32'h40200000, 32'h00000002, 1'b0, 1'b1, 24};
        vecs[11] = '{32'h3F400000, 32'h00000000, 1'b0, 1'b1, 2};
`endif
        vecs[12] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
        vecs[13] = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9};
        vecs[14] = '{32'hCB000001, 32'hFF7FFFFF, 1'b0, 1'b0, 2};
        vecs[15] = '{32'h3F000000, 32'h00000000, 1'b0, 1'b1, 2};
        vecs[16] = '{32'hCF000001, 32'h80000000, 1'b1, 1'b0, 2};
        vecs[17] = '{32'h3F800000, 32'h00000001, 1'b0, 1'b0, 25};
    end

    initial begin
        int cap;
        logic [31:0] mr;
        logic minv, minx;
        int mlat;
        rst = 1'b1;
        dval = 1'b0;
        din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check1("reset_dout", dout, 32'h0);
        check1("reset_dout_val", {31'd0, dout_val}, 32'h0);
        check1("reset_invalid", {31'd0, exc_invalid}, 32'h0);
        check1("reset_inexact", {31'd0, exc_inexact}, 32'h0);
        check1("reset_rdy", {31'd0, rdy}, 32'h1);

        // Pin the reference model to the hand-computed table, then run the vector.
        for (int i = 0; i < NV; i++) begin
            model(vecs[i].x, mr, minv, minx, mlat);
            checks++;
            if (mr !== vecs[i].r || minv !== vecs[i].inv || minx !== vecs[i].inx
                || mlat != vecs[i].lat) begin
                errors++;
                $display("FAIL model_%08h got=%08h/%0b/%0b/%0d want=%08h/%0b/%0b/%0d",
                         vecs[i].x, mr, minv, minx, mlat,
                         vecs[i].r, vecs[i].inv, vecs[i].inx, vecs[i].lat);
            end
            send(vecs[i].x);
        end

        // Abort a long conversion with reset during its fifth SHIFT cycle.
        wait_rdy();
        capture(32'h3F800001, cap);
        while (cyc < cap + 5) @(negedge clk);
        check1("abort_busy_rdy", {31'd0, rdy}, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check1("abort_dout", dout, 32'h0);
        check1("abort_dout_val", {31'd0, dout_val}, 32'h0);
        check1("abort_flags", {30'd0, exc_invalid, exc_inexact}, 32'h0);
        check1("abort_rdy", {31'd0, rdy}, 32'h1);
        $display("txn din=3f800001 aborted by reset");
        repeat (30) @(negedge clk);

        // dval held through OUT must not be accepted until IDLE.
        wait_rdy();
        capture(32'h4B800000, cap);
        push(32'h4B800000, cap);
        begin
            int k;
            k = 0;
            while (!dout_val && k < 50) begin
                @(negedge clk);
                k++;
            end
        end
        check1("hold_out_pulse", {31'd0, dout_val}, 32'h1);
        check1("hold_out_rdy", {31'd0, rdy}, 32'h0);
        din = 32'hC0490FDB;
        dval = 1'b1;
        @(negedge clk);
        check1("hold_idle_rdy", {31'd0, rdy}, 32'h1);
        @(posedge clk);
        #1;
        dval = 1'b0;
        push(32'hC0490FDB, cyc);
        wait_done();

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule
